// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences one mult/div instruction at a time through the
// multicycle multiply/divide unit. It latches the operands, fires a start
// pulse, stalls decode while the unit runs, and writes the result or an
// exception code back through the shared regfile write port.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT      = 40,
  parameter int unsigned MUL_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE = 5,
  parameter int unsigned TIMEOUT_CODE = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_op,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  output logic        stall,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  input  logic        md_result_rdy,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        wb_req,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_grant,
  output logic        md_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0] RSTATUS = 5'd30;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_WB
  } state_e;

  state_e state_q, state_d;

  logic             op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mult_q, mult_d;
  logic             div_q, div_d;
  logic             wb_req_q, wb_req_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             timeout_q, timeout_d;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: assigning a default before the case keeps every path driven,
  // so no latch is inferred for signals a branch forgets to assign.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (issue_valid) state_d = S_START;
      S_START: state_d = S_BUSY;
      S_BUSY: begin
        if (md_result_rdy) begin
          // A clean result aimed at r0 has nothing to write.
          state_d = (md_exception || (rd_q != 5'd0)) ? S_WB : S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_WB;
        end
      end
      S_WB:    if (wb_grant) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the latched instruction, counter and registered outputs.
  always_comb begin
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    mult_d    = 1'b0;
    div_d     = 1'b0;
    wb_req_d  = wb_req_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue_valid) begin
          op_d   = issue_op;
          rd_d   = issue_rd;
          a_d    = issue_a;
          b_d    = issue_b;
          // Registered here so the pulse coincides with the START cycle.
          mult_d = ~issue_op;
          div_d  = issue_op;
        end
      end
      S_START: cnt_d = '0;
      S_BUSY: begin
        if (md_result_rdy) begin
          // A ready result beats a timeout landing on the same cycle.
          if (md_exception) begin
            wb_req_d  = 1'b1;
            wb_rd_d   = RSTATUS;
            wb_data_d = op_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
          end else if (rd_q != 5'd0) begin
            wb_req_d  = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = md_result;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          wb_req_d  = 1'b1;
          wb_rd_d   = RSTATUS;
          wb_data_d = 32'(TIMEOUT_CODE);
        end else begin
          // Leaves BUSY at CNT_LAST, so the increment never wraps.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB:    if (wb_grant) wb_req_d = 1'b0;
      default: ;
    endcase
  end

  // Datapath and output registers.
  // NOTE: every flop here gets an async reset value, since a reset
  // mid-operation must leave no latched operands or pending write behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q      <= 1'b0;
      rd_q      <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      cnt_q     <= '0;
      mult_q    <= 1'b0;
      div_q     <= 1'b0;
      wb_req_q  <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      mult_q    <= mult_d;
      div_q     <= div_d;
      wb_req_q  <= wb_req_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      timeout_q <= timeout_d;
    end
  end

  // Output decode; stall comes straight from the state flops, so it is glitch-free.
  always_comb begin
    stall        = (state_q != S_IDLE);
    md_ctrl_mult = mult_q;
    md_ctrl_div  = div_q;
    md_operand_a = a_q;
    md_operand_b = b_q;
    wb_req       = wb_req_q;
    wb_rd        = wb_rd_q;
    wb_data      = wb_data_q;
    md_timeout   = timeout_q;
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed scenarios for the mult/div sequencing controller.
module tb_multdiv_ctrl;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic        issue_op;
  logic [4:0]  issue_rd;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic        stall;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_operand_a;
  logic [31:0] md_operand_b;
  logic        md_result_rdy;
  logic [31:0] md_result;
  logic        md_exception;
  logic        wb_req;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_grant;
  logic        md_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations gathered by run_op for one instruction.
  int          obs_stall, obs_mult, obs_div, obs_op_bad, obs_wb, obs_unstable;
  logic        obs_hung, obs_end_req;
  logic [4:0]  obs_rd;
  logic [31:0] obs_data;

  multdiv_ctrl dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
    .issue_a(issue_a), .issue_b(issue_b),
    .stall(stall), .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
    .md_result_rdy(md_result_rdy), .md_result(md_result), .md_exception(md_exception),
    .wb_req(wb_req), .wb_rd(wb_rd), .wb_data(wb_data), .wb_grant(wb_grant),
    .md_timeout(md_timeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  // Issue one instruction and play the multdiv unit and write-port arbiter.
  // Cycle k=0 is the START cycle; rdy is driven on k==rdy_k (never if < 0).
  // With noise set, decode keeps presenting a different instruction while stalled.
  task automatic run_op(input logic op, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int rdy_k, input logic [31:0] res,
                        input logic exc, input int grant_delay, input logic noise);
    int wb_seen;
    wb_seen = 0;
    obs_stall = 0; obs_mult = 0; obs_div = 0; obs_op_bad = 0; obs_unstable = 0;
    obs_rd = 5'd0; obs_data = 32'd0; obs_hung = 1'b1;
    issue_valid = 1'b1; issue_op = op; issue_rd = rd; issue_a = a; issue_b = b;
    tick();
    issue_valid = noise; issue_op = ~op; issue_rd = ~rd; issue_a = ~a; issue_b = ~b;
    for (int k = 0; k < 200; k++) begin
      if (!stall) begin
        obs_hung = 1'b0;
        break;
      end
      obs_stall++;
      if (md_ctrl_mult) obs_mult++;
      if (md_ctrl_div) obs_div++;
      if (md_operand_a !== a || md_operand_b !== b) obs_op_bad++;
      if (wb_req) begin
        if (wb_seen == 0) begin
          obs_rd = wb_rd;
          obs_data = wb_data;
        end else if (wb_rd !== obs_rd || wb_data !== obs_data) begin
          obs_unstable++;
        end
        wb_seen++;
      end
      md_result_rdy = (k == rdy_k);
      md_result     = (k == rdy_k) ? res : (32'hBAD0_0000 | 32'(k));
      md_exception  = (k == rdy_k) ? exc : 1'b1;
      wb_grant      = wb_req && (wb_seen > grant_delay);
      tick();
    end
    obs_wb = wb_seen;
    obs_end_req = wb_req;
    issue_valid = 1'b0; md_result_rdy = 1'b0; md_exception = 1'b0; wb_grant = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    issue_valid = 1'b0; issue_op = 1'b0; issue_rd = 5'd0; issue_a = 32'd0; issue_b = 32'd0;
    md_result_rdy = 1'b0; md_result = 32'd0; md_exception = 1'b0; wb_grant = 1'b0;
    #23;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_pulses", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    chk("reset_operand_a", md_operand_a, 32'd0);
    chk("reset_operand_b", md_operand_b, 32'd0);
    chk("reset_wb", {wb_req, md_timeout, wb_rd, 25'd0} | wb_data, 32'd0);
    #4 reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_mult();
    run_op(1'b0, 5'd3, 32'd6, 32'd7, 17, 32'd42, 1'b0, 0, 1'b0);
    chk("mult_hung", 32'(obs_hung), 32'd0);
    chk("mult_pulses", 32'(obs_mult), 32'd1);
    chk("mult_div_pulses", 32'(obs_div), 32'd0);
    chk("mult_operands_stable", 32'(obs_op_bad), 32'd0);
    chk("mult_wb_cycles", 32'(obs_wb), 32'd1);
    chk("mult_wb_rd", 32'(obs_rd), 32'd3);
    chk("mult_wb_data", obs_data, 32'd42);
    chk("mult_stall_cycles", 32'(obs_stall), 32'd19);
    chk("mult_req_drops", 32'(obs_end_req), 32'd0);
    chk("mult_no_timeout", 32'(md_timeout), 32'd0);
  endtask

  task automatic test_div_by_zero();
    run_op(1'b1, 5'd5, 32'd9, 32'd0, 33, 32'h1234, 1'b1, 0, 1'b0);
    chk("div_pulses", 32'(obs_div), 32'd1);
    chk("div_mult_pulses", 32'(obs_mult), 32'd0);
    chk("div_wb_cycles", 32'(obs_wb), 32'd1);
    chk("div_wb_rd", 32'(obs_rd), 32'd30);
    chk("div_wb_data", obs_data, 32'd5);
    chk("div_stall_cycles", 32'(obs_stall), 32'd35);
  endtask

  // Decode keeps offering another instruction here; it must be ignored.
  task automatic test_delayed_grant();
    run_op(1'b0, 5'd7, 32'hDEAD_BEEF, 32'h0000_0003, 2, 32'h1234_5678, 1'b0, 3, 1'b1);
    chk("grant_wb_cycles", 32'(obs_wb), 32'd4);
    chk("grant_wb_stable", 32'(obs_unstable), 32'd0);
    chk("grant_wb_rd", 32'(obs_rd), 32'd7);
    chk("grant_wb_data", obs_data, 32'h1234_5678);
    chk("grant_stall_cycles", 32'(obs_stall), 32'd7);
    chk("grant_single_pulse", 32'(obs_mult + obs_div), 32'd1);
    chk("grant_operands_stable", 32'(obs_op_bad), 32'd0);
    tick();
    chk("grant_noise_not_issued", 32'(stall), 32'd0);
  endtask

  task automatic test_rd_zero();
    run_op(1'b0, 5'd0, 32'd2, 32'd3, 4, 32'd6, 1'b0, 0, 1'b0);
    chk("rd0_no_write", 32'(obs_wb), 32'd0);
    chk("rd0_stall_cycles", 32'(obs_stall), 32'd5);
    run_op(1'b0, 5'd0, 32'd2, 32'd3, 4, 32'd6, 1'b1, 0, 1'b0);
    chk("rd0_exc_wb_cycles", 32'(obs_wb), 32'd1);
    chk("rd0_exc_wb_rd", 32'(obs_rd), 32'd30);
    chk("rd0_exc_wb_data", obs_data, 32'd4);
  endtask

  task automatic test_min_occupancy();
    run_op(1'b1, 5'd12, 32'd100, 32'd10, 1, 32'd10, 1'b0, 0, 1'b0);
    chk("min_stall_cycles", 32'(obs_stall), 32'd3);
    chk("min_wb_data", obs_data, 32'd10);
  endtask

  // rdy lands on the 40th BUSY cycle, the same cycle the timeout would fire.
  task automatic test_rdy_vs_timeout();
    run_op(1'b0, 5'd9, 32'd11, 32'd13, 40, 32'd143, 1'b0, 0, 1'b0);
    chk("race_wb_rd", 32'(obs_rd), 32'd9);
    chk("race_wb_data", obs_data, 32'd143);
    chk("race_no_timeout", 32'(md_timeout), 32'd0);
    chk("race_stall_cycles", 32'(obs_stall), 32'd42);
  endtask

  task automatic test_timeout();
    run_op(1'b0, 5'd4, 32'd1, 32'd1, -1, 32'd0, 1'b0, 0, 1'b0);
    chk("to_flag", 32'(md_timeout), 32'd1);
    chk("to_wb_rd", 32'(obs_rd), 32'd30);
    chk("to_wb_data", obs_data, 32'd6);
    chk("to_stall_cycles", 32'(obs_stall), 32'd42);
    run_op(1'b0, 5'd8, 32'd3, 32'd5, 3, 32'd15, 1'b0, 0, 1'b0);
    chk("to_sticky", 32'(md_timeout), 32'd1);
    chk("to_next_wb_data", obs_data, 32'd15);
  endtask

  task automatic test_reset_mid_busy();
    int bad;
    bad = 0;
    issue_valid = 1'b1; issue_op = 1'b1; issue_rd = 5'd6; issue_a = 32'd77; issue_b = 32'd7;
    tick();
    issue_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("rst_busy_before", 32'(stall), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_stall", 32'(stall), 32'd0);
    chk("rst_async_operand_a", md_operand_a, 32'd0);
    chk("rst_async_timeout", 32'(md_timeout), 32'd0);
    #2 reset = 1'b1;
    md_result_rdy = 1'b1; md_result = 32'd11; md_exception = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (wb_req || stall) bad++;
    end
    md_result_rdy = 1'b0;
    chk("rst_stray_rdy_ignored", 32'(bad), 32'd0);
    run_op(1'b1, 5'd6, 32'd77, 32'd7, 5, 32'd11, 1'b0, 0, 1'b0);
    chk("rst_new_div_pulses", 32'(obs_div), 32'd1);
    chk("rst_new_wb_rd", 32'(obs_rd), 32'd6);
    chk("rst_new_wb_data", obs_data, 32'd11);
    chk("rst_new_stall_cycles", 32'(obs_stall), 32'd7);
  endtask

  initial begin
    test_reset();
    test_basic_mult();
    test_div_by_zero();
    test_delayed_grant();
    test_rd_zero();
    test_min_occupancy();
    test_rdy_vs_timeout();
    test_timeout();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencing controller between the processor decode stage and the multicycle multiply/divide unit.
- Accepts one mult/div instruction at a time and latches its operands.
- Fires a one-cycle start pulse into the multdiv unit, stalls the pipeline while the unit runs, and captures the result or exception.
- Writes back through the regfile write port it shares with the main pipeline. Exceptions write rstatus (r30) per the processor's exception codes.

Parameters:
TIMEOUT, 40, max cycles in BUSY awaiting md_result_rdy before a forced timeout
MUL_EXC_CODE, 4, rstatus value on multiply overflow
DIV_EXC_CODE, 5, rstatus value on divide-by-zero/exception
TIMEOUT_CODE, 6, rstatus value on timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
issue_valid  in  1  decode holds a mult/div instruction this cycle
issue_op  in  1  0 = mult, 1 = div
issue_rd  in  5  destination register
issue_a  in  32  operand A
issue_b  in  32  operand B
stall  out  1  freeze PC/fetch/decode
md_ctrl_mult  out  1  one-cycle multiply start pulse
md_ctrl_div  out  1  one-cycle divide start pulse
md_operand_a  out  32  latched operand A, stable through BUSY
md_operand_b  out  32  latched operand B, stable through BUSY
md_result_rdy  in  1  multdiv result valid, single cycle
md_result  in  32  multdiv result
md_exception  in  1  multdiv exception, qualified by md_result_rdy
wb_req  out  1  request for the shared regfile write port
wb_rd  out  5  write-back register
wb_data  out  32  write-back data
wb_grant  in  1  write port granted this cycle; the pipeline has priority
md_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including md_timeout and the latched operands/rd/op.
  - Reset mid-operation abandons the operation. No write-back occurs, and a later md_result_rdy is ignored in IDLE.
- Outputs:
  - All outputs are registered except stall.
  - stall = (state != IDLE), decoded from registered state, so it is glitch-free.
- IDLE:
  - If issue_valid=1: latch op/rd/a/b and go to START.
  - The issuing instruction is accepted in this cycle and is not itself stalled. stall rises on the next cycle.
- START (1 cycle):
  - md_ctrl_mult = ~op or md_ctrl_div = op, exactly one cycle high.
  - Cycle counter cleared to 0. Next state BUSY.
- BUSY:
  - Counter increments each cycle.
  - If md_result_rdy=1, capture the result:
    - md_exception=0: wb_rd = latched rd, wb_data = md_result.
    - md_exception=1: wb_rd = 30, wb_data = MUL_EXC_CODE or DIV_EXC_CODE according to op.
    - Then go to WB, except for a non-exception result with rd=0, which goes straight to IDLE with no write.
  - If the counter reaches TIMEOUT-1 and rdy is still 0: md_timeout=1 (sticky until reset), wb_rd=30, wb_data=TIMEOUT_CODE, go to WB.
  - If rdy and the timeout occur in the same cycle, rdy wins.
- WB:
  - wb_req=1 with wb_rd and wb_data held constant until wb_grant=1 is sampled.
  - wb_req drops the cycle after the grant. Next state IDLE, and stall drops the same cycle.
- issue_valid outside IDLE is ignored; the pipeline is stalled.
- md_result_rdy outside BUSY is ignored.
- Minimum occupancy: IDLE→START→BUSY(1)→WB(1) gives stall high for 3 cycles when rdy arrives on the first BUSY cycle and the grant is immediate.
- Operands are captured unmodified at full 32 bits. The controller performs no arithmetic beyond the counter, which is $clog2(TIMEOUT) bits and never wraps because the timeout exits BUSY first.

Test Plan:
- Basic multiply: issue mult a=6, b=7, rd=3. Drive rdy 17 cycles after the md_ctrl_mult pulse with result=42; grant is immediate. → One md_ctrl_mult pulse, md_ctrl_div stays 0. Operands stay 6/7 throughout BUSY. wb_req for 1 cycle with wb_rd=3, wb_data=42. stall high for exactly 19 cycles.
- Divide-by-zero: issue div a=9, b=0, rd=5. Return rdy with exception=1 after 33 cycles. → Write to wb_rd=30 with wb_data=5; no write to r5.
- Delayed grant: wb_grant held 0 for 3 cycles after wb_req rises. → wb_req, wb_rd and wb_data stable for 4 cycles. stall releases the cycle after the grant.
- rd=0 without exception: → wb_req never asserts and the controller returns to IDLE the cycle after rdy. The same case with exception=1 still writes r30.
- Timeout: rdy never arrives. → After TIMEOUT=40 BUSY cycles, md_timeout=1 and a write of r30=6 occurs. md_timeout stays 1 through a following normal multiply.
- Reset mid-BUSY: assert reset=0 asynchronously at BUSY cycle 10. → Outputs clear immediately with no clock edge needed. A subsequent stray rdy=1 produces no wb_req. A new issue starts normally.
